dbns_converter_param: RTL and testbench

- Parametrised multi-cycle converter from an unsigned binary integer to a greedy double-base (2,3) representation.
- The representation is X = sum of 2^a_k * 3^b_k over up to TERMS terms.
- It is the next generation of the fixed 16-bit DBNS converter: generic width, term count and exponent range, plus valid/ready handshakes.
- It adds term-count, residual and exactness outputs. It sits ahead of the DBNS multiplier datapath.

---
 rtl/dbns_converter_param.sv | 206 ++++++++++++++++++++
 tb/tb_dbns_converter_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbns_converter_param.sv
// Greedy double-base (2,3) converter.
// Splits an unsigned integer into up to TERMS terms of the form 2^a * 3^b.
// Each term is chosen greedily as the largest such value that does not exceed
// the running residual. Each term costs one SEARCH sweep over b = 0..B_MAX and
// one COMMIT cycle. Handshakes are valid/ready on both sides.
module dbns_converter_param #(
  parameter int WIDTH = 16,
  parameter int TERMS = 4,
  parameter int B_MAX = 10,
  parameter int AW    = $clog2(WIDTH),
  parameter int BW    = $clog2(B_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TERMS*(AW+BW)-1:0]     out_terms,
  output logic [$clog2(TERMS+1)-1:0]   out_count,
  output logic [WIDTH-1:0]             out_residual,
  output logic                         out_exact
);

  localparam int TW = AW + BW;
  localparam int CW = $clog2(TERMS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Index of the most significant set bit (0 for a zero operand).
  function automatic logic [AW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [AW-1:0] idx;
    idx = {AW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = AW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t                 state_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   exact_r;
  logic [WIDTH-1:0]       residual_r;
  logic [TERMS*TW-1:0]    terms_r;
  logic [CW-1:0]          count_r;
  logic [BW-1:0]          b_r;
  logic [WIDTH:0]         p_r;        // 3^b, one guard bit wider than the data
  logic [WIDTH-1:0]       best_r;
  logic [AW-1:0]          best_a_r;
  logic [BW-1:0]          best_b_r;

  logic [WIDTH:0]         r_ext_s;
  logic [AW-1:0]          msb_r_s;
  logic [AW-1:0]          msb_p_s;
  logic [AW-1:0]          shift0_s;
  logic [WIDTH:0]         p_shift0_s;
  logic [AW-1:0]          cand_a_s;
  logic [WIDTH:0]         cand_val_s;
  logic                   cand_ok_s;
  logic                   cand_better_s;
  logic [WIDTH-1:0]       residual_next_s;
  logic [CW-1:0]          count_next_s;

  // Largest a with (p << a) <= R for the current b, evaluated at WIDTH+1 bits.
  always_comb begin
    r_ext_s    = {1'b0, residual_r};
    msb_r_s    = msb_index(residual_r);
    msb_p_s    = msb_index(p_r[WIDTH-1:0]);
    cand_ok_s  = (p_r <= r_ext_s);
    if (cand_ok_s) begin
      shift0_s = msb_r_s - msb_p_s;
    end else begin
      shift0_s = {AW{1'b0}};
    end
    p_shift0_s = p_r << shift0_s;
    // Aligning the leading ones can overshoot R by less than one binary step.
    if (cand_ok_s && (p_shift0_s > r_ext_s)) begin
      cand_a_s   = shift0_s - AW'(1);
      cand_val_s = p_r << cand_a_s;
    end else begin
      cand_a_s   = shift0_s;
      cand_val_s = p_shift0_s;
    end
    cand_better_s   = cand_ok_s && (cand_val_s > {1'b0, best_r});
    residual_next_s = residual_r - best_r;
    count_next_s    = count_r + CW'(1);
  end

  // Conversion FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      exact_r     <= 1'b1;
      residual_r  <= {WIDTH{1'b0}};
      terms_r     <= {(TERMS*TW){1'b0}};
      count_r     <= {CW{1'b0}};
      b_r         <= {BW{1'b0}};
      p_r         <= {{WIDTH{1'b0}}, 1'b1};
      best_r      <= {WIDTH{1'b0}};
      best_a_r    <= {AW{1'b0}};
      best_b_r    <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            residual_r <= in_data;
            terms_r    <= {(TERMS*TW){1'b0}};
            count_r    <= {CW{1'b0}};
            b_r        <= {BW{1'b0}};
            p_r        <= {{WIDTH{1'b0}}, 1'b1};
            best_r     <= {WIDTH{1'b0}};
            best_a_r   <= {AW{1'b0}};
            best_b_r   <= {BW{1'b0}};
            in_ready_r <= 1'b0;
            if (in_data == {WIDTH{1'b0}}) begin
              // Zero needs no terms; valid follows from DONE one edge later.
              exact_r <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              exact_r <= 1'b0;
              state_r <= ST_SEARCH;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_SEARCH: begin
          if (cand_better_s) begin
            best_r   <= cand_val_s[WIDTH-1:0];
            best_a_r <= cand_a_s;
            best_b_r <= b_r;
          end else begin
            best_r   <= best_r;
          end
          p_r <= p_r + (p_r << 1);
          b_r <= b_r + BW'(1);
          if (b_r == BW'(B_MAX)) begin
            state_r <= ST_COMMIT;
          end else begin
            state_r <= ST_SEARCH;
          end
        end
        ST_COMMIT: begin
          for (int k = 0; k < TERMS; k++) begin
            if (count_r == CW'(k)) begin
              terms_r[k*TW +: TW] <= {best_a_r, best_b_r};
            end else begin
              terms_r[k*TW +: TW] <= terms_r[k*TW +: TW];
            end
          end
          count_r    <= count_next_s;
          residual_r <= residual_next_s;
          exact_r    <= (residual_next_s == {WIDTH{1'b0}});
          if ((residual_next_s == {WIDTH{1'b0}}) || (count_next_s == CW'(TERMS))) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            b_r      <= {BW{1'b0}};
            p_r      <= {{WIDTH{1'b0}}, 1'b1};
            best_r   <= {WIDTH{1'b0}};
            best_a_r <= {AW{1'b0}};
            best_b_r <= {BW{1'b0}};
            state_r  <= ST_SEARCH;
          end
        end
        ST_DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_terms    = terms_r;
  assign out_count    = count_r;
  assign out_residual = residual_r;
  assign out_exact    = exact_r;

endmodule

// File: tb/tb_dbns_converter_param.sv
// Bench for dbns_converter_param: directed cases plus randomized words checked
// against an exhaustive greedy search model. A second instance with TERMS=2
// exercises truncation.
module tb_dbns_converter_param;

  localparam int WIDTH = 16;
  localparam int B_MAX = 10;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] out_terms;
  logic [2:0]  out_count;
  logic [15:0] out_residual;
  logic        out_exact;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] out_terms2;
  logic [1:0]  out_count2;
  logic [15:0] out_residual2;
  logic        out_exact2;

  int n_cmp;
  int n_fail;

  dbns_converter_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_terms(out_terms), .out_count(out_count),
    .out_residual(out_residual), .out_exact(out_exact)
  );

  dbns_converter_param #(.TERMS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_terms(out_terms2), .out_count(out_count2),
    .out_residual(out_residual2), .out_exact(out_exact2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Greedy reference: exhaustively pick the largest 2^a*3^b <= residual.
  task automatic model(input longint v, input int max_terms, output logic [63:0] terms,
                       output int count, output longint res, output int lat);
    longint best, t, p3;
    int ba, bb;
    res = v; count = 0; terms = 64'd0;
    while (res != 0 && count < max_terms) begin
      best = 0; ba = 0; bb = 0;
      p3 = 1;
      for (int b = 0; b <= B_MAX; b++) begin
        for (int a = 0; a < WIDTH; a++) begin
          t = (longint'(1) << a) * p3;
          if (t <= res && t > best) begin best = t; ba = a; bb = b; end
        end
        p3 = p3 * 3;
      end
      terms[count*8 +: 8] = {ba[3:0], bb[3:0]};
      res = res - best;
      count++;
    end
    lat = (count == 0) ? 1 : count * (B_MAX + 2);
  endtask

  // Present one word, wait for the accept edge, then count edges to out_valid.
  task automatic run_conv(input logic [15:0] v, input bit sel, output int lat);
    int guard;
    @(negedge clk);
    in_data = v;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    guard = 0;
    while (((sel ? in_ready2 : in_ready) !== 1'b1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
    in_data = ~v;  // must be ignored while busy
    lat = 0;
    while (((sel ? out_valid2 : out_valid) !== 1'b1) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out(input bit sel);
    if (sel) out_ready2 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    in_data = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_terms !== 32'd0) begin n_fail++; $display("FAIL reset_terms: got %h want 0", out_terms); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_cmp++; if (out_residual !== 16'd0) begin n_fail++; $display("FAIL reset_residual: got %0d want 0", out_residual); end
    n_cmp++; if (out_exact !== 1'b1) begin n_fail++; $display("FAIL reset_exact: got %b want 1", out_exact); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_term;
    int lat;
    run_conv(16'd3888, 1'b0, lat);
    n_cmp++; if (lat !== 12) begin n_fail++; $display("FAIL single_latency: got %0d want 12", lat); end
    n_cmp++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_count); end
    n_cmp++; if (out_terms !== 32'h0000_0045) begin n_fail++; $display("FAIL single_terms: got %h want 00000045", out_terms); end
    n_cmp++; if (out_residual !== 16'd0 || out_exact !== 1'b1) begin
      n_fail++; $display("FAIL single_exact: got res=%0d exact=%b want 0/1", out_residual, out_exact); end
    release_out(1'b0);
  endtask

  task automatic test_two_terms;
    int lat;
    run_conv(16'd100, 1'b0, lat);
    n_cmp++; if (lat !== 24) begin n_fail++; $display("FAIL two_latency: got %0d want 24", lat); end
    n_cmp++; if (out_terms !== 32'h0000_2051) begin n_fail++; $display("FAIL two_terms: got %h want 00002051", out_terms); end
    n_cmp++; if (out_count !== 3'd2 || out_exact !== 1'b1) begin
      n_fail++; $display("FAIL two_count: got cnt=%0d exact=%b want 2/1", out_count, out_exact); end
    release_out(1'b0);
  endtask

  task automatic test_full_range;
    int lat;
    run_conv(16'd65535, 1'b0, lat);
    n_cmp++; if (lat !== 48) begin n_fail++; $display("FAIL full_latency: got %0d want 48", lat); end
    n_cmp++; if (out_terms !== 32'h2105_A185) begin n_fail++; $display("FAIL full_terms: got %h want 2105a185", out_terms); end
    n_cmp++; if (out_count !== 3'd4 || out_exact !== 1'b1 || out_residual !== 16'd0) begin
      n_fail++; $display("FAIL full_count: got cnt=%0d exact=%b res=%0d want 4/1/0", out_count, out_exact, out_residual); end
    release_out(1'b0);
  endtask

  task automatic test_truncation;
    int lat;
    run_conv(16'd65535, 1'b1, lat);
    n_cmp++; if (lat !== 24) begin n_fail++; $display("FAIL trunc_latency: got %0d want 24", lat); end
    n_cmp++; if (out_terms2 !== 16'hA185) begin n_fail++; $display("FAIL trunc_terms: got %h want a185", out_terms2); end
    n_cmp++; if (out_count2 !== 2'd2) begin n_fail++; $display("FAIL trunc_count: got %0d want 2", out_count2); end
    n_cmp++; if (out_residual2 !== 16'd255 || out_exact2 !== 1'b0) begin
      n_fail++; $display("FAIL trunc_residual: got res=%0d exact=%b want 255/0", out_residual2, out_exact2); end
    release_out(1'b1);
  endtask

  task automatic test_zero_backpressure;
    int lat;
    run_conv(16'd0, 1'b0, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_cmp++; if (out_count !== 3'd0 || out_exact !== 1'b1 || out_terms !== 32'd0) begin
      n_fail++; $display("FAIL zero_result: got cnt=%0d exact=%b terms=%h want 0/1/0", out_count, out_exact, out_terms); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 3'd0 || out_exact !== 1'b1) begin
        n_fail++; $display("FAIL zero_hold: got valid=%b ready=%b cnt=%0d exact=%b want 1/0/0/1",
                           out_valid, in_ready, out_count, out_exact); end
    end
    release_out(1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_after_handshake: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk); in_data = 16'd65535; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_count !== 3'd0 || out_terms !== 32'd0 ||
                 out_residual !== 16'd0 || out_exact !== 1'b1) begin
      n_fail++; $display("FAIL midreset_clear: got valid=%b cnt=%0d terms=%h res=%0d exact=%b want 0/0/0/0/1",
                         out_valid, out_count, out_terms, out_residual, out_exact); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    run_conv(16'd3888, 1'b0, lat);
    n_cmp++; if (lat !== 12 || out_terms !== 32'h0000_0045 || out_count !== 3'd1 || out_exact !== 1'b1) begin
      n_fail++; $display("FAIL midreset_reconvert: got lat=%0d terms=%h cnt=%0d exact=%b want 12/00000045/1/1",
                         lat, out_terms, out_count, out_exact); end
    release_out(1'b0);
  endtask

  task automatic test_random;
    logic [63:0] et;
    int ec, elat, lat, hold;
    longint er;
    logic [15:0] v;
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: v = 16'($urandom_range(0, 65535));
        1: v = 16'($urandom_range(0, 300));
        default: v = 16'($urandom_range(40000, 65535));
      endcase
      model(longint'(v), 4, et, ec, er, elat);
      run_conv(v, 1'b0, lat);
      n_cmp++; if (lat !== elat || out_terms !== et[31:0] || out_count !== 3'(ec) ||
                   out_residual !== 16'(er) || out_exact !== (er == 0)) begin
        n_fail++; $display("FAIL random_%0d: in=%0d got lat=%0d terms=%h cnt=%0d res=%0d exact=%b want %0d/%h/%0d/%0d/%b",
                           i, v, lat, out_terms, out_count, out_residual, out_exact,
                           elat, et[31:0], ec, er, (er == 0)); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_terms !== et[31:0]) begin
          n_fail++; $display("FAIL random_hold_%0d: got valid=%b terms=%h want 1/%h", i, out_valid, out_terms, et[31:0]); end
      end
      release_out(1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] et;
    int ec, elat, lat;
    longint er;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(1, 65535));
      model(longint'(v), 2, et, ec, er, elat);
      run_conv(v, 1'b1, lat);
      n_cmp++; if (lat !== elat || out_terms2 !== et[15:0] || out_count2 !== 2'(ec) ||
                   out_residual2 !== 16'(er) || out_exact2 !== (er == 0)) begin
        n_fail++; $display("FAIL b2b_%0d: in=%0d got lat=%0d terms=%h cnt=%0d res=%0d want %0d/%h/%0d/%0d",
                           i, v, lat, out_terms2, out_count2, out_residual2, elat, et[15:0], ec, er); end
      release_out(1'b1);
      n_cmp++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got ready=%b valid=%b want 1/0", i, in_ready2, out_valid2); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single_term();
    test_two_terms();
    test_full_range();
    test_truncation();
    test_zero_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
